dbg_uart: RTL and testbench

DBG_UART -- requirements
Module: dbg_uart

---
 rtl/dbg_uart.sv | 171 +++++++++++++++++
 tb/tb_dbg_uart.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_uart.sv
// Byte-serial debug port: decodes UART command bytes into bus accesses on a
// shared system bus and streams response bytes back, paced at the UART frame rate.
module dbg_uart #(
    parameter int TX_GAP  = 4340,
    parameter int ACC_CYC = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dix,
    input  logic [7:0]  id,
    output logic        dox,
    output logic [7:0]  od,
    output logic        csu,
    output logic [15:0] addru,
    output logic        ru,
    output logic [1:0]  wru,
    input  logic [15:0] data,
    output logic [15:0] datau,
    input  logic [7:0]  status
);

    localparam int GW = (TX_GAP  < 2) ? 1 : $clog2(TX_GAP + 1);
    localparam int AW = (ACC_CYC < 2) ? 1 : $clog2(ACC_CYC + 1);

    localparam logic [7:0] C_SETADDR = 8'h01;
    localparam logic [7:0] C_READ    = 8'h02;
    localparam logic [7:0] C_WRITE   = 8'h03;
    localparam logic [7:0] C_WRITEB  = 8'h04;
    localparam logic [7:0] C_STATUS  = 8'h05;
    localparam logic [7:0] C_ADDRQ   = 8'h06;

    typedef enum logic [1:0] {S_IDLE, S_ARGS, S_ACCESS, S_SEND} state_t;

    state_t          r_state;
    logic [7:0]      r_cmd;
    logic [1:0]      r_argcnt;
    logic [7:0]      r_hi;
    logic [AW-1:0]   r_acc;
    logic [GW-1:0]   r_gap;
    logic [1:0]      r_nsend;
    logic [15:0]     r_txbuf;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cmd    <= '0;
            r_argcnt <= '0;
            r_hi     <= '0;
            r_acc    <= '0;
            r_gap    <= '0;
            r_nsend  <= '0;
            r_txbuf  <= '0;
            csu      <= 1'b0;
            ru       <= 1'b0;
            wru      <= 2'b00;
            addru    <= '0;
            datau    <= '0;
            dox      <= 1'b0;
            od       <= '0;
        end else begin
            dox <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (dix) begin
                        case (id)
                            C_SETADDR, C_WRITE: begin
                                r_cmd    <= id;
                                r_argcnt <= 2'd2;
                                r_state  <= S_ARGS;
                            end
                            C_WRITEB: begin
                                r_cmd    <= id;
                                r_argcnt <= 2'd1;
                                r_state  <= S_ARGS;
                            end
                            C_READ: begin
                                r_cmd   <= id;
                                csu     <= 1'b1;
                                ru      <= 1'b1;
                                wru     <= 2'b00;
                                r_acc   <= '0;
                                r_state <= S_ACCESS;
                            end
                            C_STATUS: begin
                                r_txbuf <= {status, 8'h00};
                                r_nsend <= 2'd1;
                                r_gap   <= '0;
                                r_state <= S_SEND;
                            end
                            C_ADDRQ: begin
                                r_txbuf <= addru;
                                r_nsend <= 2'd2;
                                r_gap   <= '0;
                                r_state <= S_SEND;
                            end
                            default: ;
                        endcase
                    end
                end
                S_ARGS: begin
                    if (dix) begin
                        r_argcnt <= r_argcnt - 2'd1;
                        if (r_argcnt == 2'd2) begin
                            r_hi <= id;
                        end else begin
                            // Last argument byte: either finish SETADDR or launch the write.
                            case (r_cmd)
                                C_SETADDR: begin
                                    addru   <= {r_hi, id};
                                    r_state <= S_IDLE;
                                end
                                C_WRITE: begin
                                    datau   <= {r_hi, id};
                                    csu     <= 1'b1;
                                    wru     <= 2'b11;
                                    r_acc   <= '0;
                                    r_state <= S_ACCESS;
                                end
                                default: begin
                                    datau   <= {id, id};
                                    csu     <= 1'b1;
                                    wru     <= addru[0] ? 2'b01 : 2'b10;
                                    r_acc   <= '0;
                                    r_state <= S_ACCESS;
                                end
                            endcase
                        end
                    end
                end
                S_ACCESS: begin
                    if (r_acc == AW'(ACC_CYC - 1)) begin
                        csu <= 1'b0;
                        ru  <= 1'b0;
                        wru <= 2'b00;
                        if (r_cmd == C_READ) begin
                            r_txbuf <= data;
                            r_nsend <= 2'd2;
                            r_gap   <= '0;
                            addru   <= addru + 16'd2;
                            r_state <= S_SEND;
                        end else if (r_cmd == C_WRITE) begin
                            addru   <= addru + 16'd2;
                            r_state <= S_IDLE;
                        end else begin
                            addru   <= addru + 16'd1;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_acc <= r_acc + 1'b1;
                    end
                end
                S_SEND: begin
                    // Gap counter paces both the next byte and the final return to IDLE.
                    if (r_gap != '0) begin
                        r_gap <= r_gap - 1'b1;
                    end else if (r_nsend != 2'd0) begin
                        dox     <= 1'b1;
                        od      <= r_txbuf[15:8];
                        r_txbuf <= {r_txbuf[7:0], 8'h00};
                        r_nsend <= r_nsend - 2'd1;
                        r_gap   <= GW'(TX_GAP - 1);
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dbg_uart.sv
// Directed bench for dbg_uart: byte command sequences with hand-computed bus and response values.
module tb_dbg_uart;

    localparam int TG = 20;
    localparam int AC = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        dix = 1'b0;
    logic [7:0]  id = '0;
    logic        dox;
    logic [7:0]  od;
    logic        csu;
    logic [15:0] addru;
    logic        ru;
    logic [1:0]  wru;
    logic [15:0] data = '0;
    logic [15:0] datau;
    logic [7:0]  status = '0;

    dbg_uart #(.TX_GAP(TG), .ACC_CYC(AC)) dut (
        .clk(clk), .reset(reset), .dix(dix), .dox(dox), .id(id), .od(od),
        .csu(csu), .addru(addru), .ru(ru), .wru(wru), .data(data),
        .datau(datau), .status(status)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    int         cyc = 0;
    logic [7:0] dox_od[$];
    int         dox_t[$];
    int         csu_n = 0;
    logic [1:0] m_wru;
    logic       m_ru;
    logic [15:0] m_datau, m_addr;
    logic       nz = 1'b0;
    logic       bad_idle = 1'b0;

    // Monitor samples on the falling edge; stimulus moves 2 ns after the rising edge.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (dox) begin
            dox_od.push_back(od);
            dox_t.push_back(cyc);
        end
        if (csu) begin
            csu_n   <= csu_n + 1;
            m_wru   <= wru;
            m_ru    <= ru;
            m_datau <= datau;
            m_addr  <= addru;
        end else if (ru || wru != 2'b00) begin
            bad_idle <= 1'b1;
        end
        if (addru != 16'h0) nz <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clr();
        @(posedge clk); #2;
        dox_od.delete();
        dox_t.delete();
        csu_n = 0;
        m_wru = '0; m_ru = 1'b0; m_datau = '0; m_addr = '0;
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk); #2;
        dix = 1'b1; id = b;
        @(posedge clk); #2;
        dix = 1'b0; id = '0;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        reset = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
    endtask

    task automatic wait_dox(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (dox_od.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        if (dox_od.size() < n) chk({tag, "_timeout"}, dox_od.size(), n);
    endtask

    initial begin
        do_reset();
        tick(1);
        chk("rst_csu", csu, 0);
        chk("rst_ru", ru, 0);
        chk("rst_wru", wru, 0);
        chk("rst_addru", addru, 0);
        chk("rst_datau", datau, 0);
        chk("rst_dox", dox, 0);
        chk("rst_od", od, 0);

        // SETADDR then ADDR? readback with exact pacing
        clr();
        send(8'h01); send(8'h12); send(8'h34);
        tick(1);
        chk("setaddr", addru, 16'h1234);
        send(8'h06);
        wait_dox("addrq", 2, 3 * TG);
        if (dox_od.size() >= 2) begin
            chk("addrq_b0", dox_od[0], 8'h12);
            chk("addrq_b1", dox_od[1], 8'h34);
            chk("addrq_gap", dox_t[1] - dox_t[0], TG);
        end
        chk("setaddr_nobus", csu_n, 0);
        tick(TG + 4);

        // WRITE word
        clr();
        send(8'h01); send(8'h20); send(8'h00);
        send(8'h03); send(8'hAB); send(8'hCD);
        tick(5);
        chk("wr_csu_n", csu_n, AC);
        chk("wr_wru", m_wru, 2'b11);
        chk("wr_ru", m_ru, 0);
        chk("wr_addr", m_addr, 16'h2000);
        chk("wr_datau", m_datau, 16'hABCD);
        chk("wr_addr_after", addru, 16'h2002);
        chk("wr_nodox", dox_od.size(), 0);
        chk("wr_datau_hold", datau, 16'hABCD);

        // WRITEB odd then even address
        clr();
        send(8'h01); send(8'h20); send(8'h01);
        send(8'h04); send(8'h5A);
        tick(5);
        chk("wb_csu_n", csu_n, AC);
        chk("wb_wru", m_wru, 2'b01);
        chk("wb_datau", m_datau, 16'h5A5A);
        chk("wb_addr_after", addru, 16'h2002);
        clr();
        send(8'h04); send(8'h77);
        tick(5);
        chk("wb2_wru", m_wru, 2'b10);
        chk("wb2_datau", m_datau, 16'h7777);
        chk("wb2_addr_after", addru, 16'h2003);

        // READ
        clr();
        data = 16'hBEEF;
        send(8'h01); send(8'h20); send(8'h00);
        send(8'h02);
        wait_dox("rd", 2, 3 * TG);
        chk("rd_csu_n", csu_n, AC);
        chk("rd_ru", m_ru, 1);
        chk("rd_wru", m_wru, 0);
        chk("rd_addr", m_addr, 16'h2000);
        if (dox_od.size() >= 2) begin
            chk("rd_b0", dox_od[0], 8'hBE);
            chk("rd_b1", dox_od[1], 8'hEF);
            chk("rd_gap", dox_t[1] - dox_t[0], TG);
        end
        chk("rd_addr_after", addru, 16'h2002);
        tick(TG + 4);
        data = 16'h0;

        // STATUS, then an unknown command byte
        clr();
        status = 8'h11;
        send(8'h05);
        status = 8'h99;
        wait_dox("st", 1, 3 * TG);
        tick(3 * TG);
        chk("st_count", dox_od.size(), 1);
        if (dox_od.size() >= 1) chk("st_od", dox_od[0], 8'h11);
        clr();
        send(8'h7F);
        tick(TG);
        chk("bad_nodox", dox_od.size(), 0);
        chk("bad_nobus", csu_n, 0);
        send(8'h06);
        wait_dox("bad_idle", 2, 3 * TG);
        if (dox_od.size() >= 2) begin
            chk("bad_q0", dox_od[0], 8'h20);
            chk("bad_q1", dox_od[1], 8'h02);
        end
        tick(TG + 4);

        // Address wrap for word and byte steps
        clr();
        send(8'h01); send(8'hFF); send(8'hFE);
        send(8'h03); send(8'h00); send(8'h00);
        tick(5);
        chk("wrap_w", addru, 16'h0000);
        send(8'h01); send(8'hFF); send(8'hFF);
        send(8'h04); send(8'h00);
        tick(5);
        chk("wrap_b_wru", m_wru, 2'b01);
        chk("wrap_b", addru, 16'h0000);

        // Partial SETADDR abandoned by reset
        do_reset();
        tick(1);
        clr();
        nz = 1'b0;
        status = 8'h22;
        send(8'h01); send(8'hFF);
        do_reset();
        send(8'h05);
        wait_dox("abort", 1, 3 * TG);
        tick(3 * TG);
        chk("abort_count", dox_od.size(), 1);
        if (dox_od.size() >= 1) chk("abort_od", dox_od[0], 8'h22);
        chk("abort_addr0", nz, 0);

        // Reset mid-SEND kills the second byte
        clr();
        send(8'h01); send(8'h56); send(8'h78);
        send(8'h06);
        wait_dox("midsend", 1, 3 * TG);
        do_reset();
        tick(3 * TG);
        chk("midsend_count", dox_od.size(), 1);
        chk("midsend_addr", addru, 16'h0000);
        chk("midsend_od", od, 8'h00);

        chk("idle_bus_clean", bad_idle, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
